pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of all PC/address ports.
REQ-002 Parameter RESET_VEC, default 32'h0000_3000, first fetch address after reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180, exception handler entry.
REQ-004 Parameters IM_LO/IM_HI, default 32'h0000_3000/32'h0000_6FFC, legal fetch window, inclusive.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hazard stall; F and D frozen, D redirect ignored.
REQ-008 fetch_wait  in  1  instruction memory not ready; F held, D may advance.
REQ-009 pc4_d  in  ADDR_W  PC+4 of the D-stage instruction.
REQ-010 idx26  in  26  D-stage instr[25:0]; [15:0] is the branch offset.
REQ-011 rs_val  in  ADDR_W  forwarded rs value, jr/jalr target.
REQ-012 eq, gt, lt  in  1 each  D-stage compare flags.
REQ-013 brop  in  3  0 none, 1 beq, 2 bne, 3 bgtz, 4 blez, 5 bgez, 6 bltz, 7 reserved (never taken).
REQ-014 is_j, is_jr  in  1 each  j/jal, jr/jalr in D; one-hot with brop!=0.
REQ-015 exc_req, eret_req  in  1 each  flush to EXC_VEC / return to epc.
REQ-016 epc  in  ADDR_W  return address for eret.
REQ-017 pc_f, pc4_f  out  ADDR_W  current fetch PC and pc_f+4.
REQ-018 adel_f  out  1  fetch address error for pc_f.
REQ-019 pend  out  1  redirect latched and awaiting fetch_wait release.

Function
REQ-020 take_br SHALL be (brop1&eq)|(brop2&!eq)|(brop3&gt)|(brop4&!gt)|(brop5&!lt)|(brop6&lt).
REQ-021 br_tgt SHALL be pc4_d + sign_ext(idx26[15:0])<<2, modulo 2^ADDR_W; j_tgt SHALL be {pc4_d[ADDR_W-1:28], idx26, 2'b00}.
REQ-022 d_redir SHALL be (take_br|is_j|is_jr)&!stall; target priority br_tgt > j_tgt > rs_val.
REQ-023 Redirect priority each cycle: exc_req > eret_req > pending > d_redir > pc_f+4.
REQ-024 exc_req and eret_req SHALL override stall; with !fetch_wait they load pc_f next edge.
REQ-025 With !fetch_wait, !stall: pc_f SHALL load highest-priority source next edge, zero-cycle redirect (delay slot already in F).
REQ-026 With stall, no exc/eret: pc_f SHALL hold, no state change.
REQ-027 With fetch_wait: pc_f SHALL hold; any exc/eret/d_redir SHALL be captured in pending register (pend=1 next cycle).
REQ-028 Pending merge: new source replaces held one only if higher or equal priority; exc never displaced by branch or eret.
REQ-029 First edge with fetch_wait=0 SHALL load pending target into pc_f and clear pend; simultaneous new exc_req wins and also clears pend.
REQ-030 adel_f SHALL be combinational from pc_f: pc_f[1:0]!=0 or pc_f<IM_LO or pc_f>IM_HI.
REQ-031 pc4_f SHALL equal pc_f+4, wrapping modulo 2^ADDR_W.

Reset
REQ-032 reset low SHALL asynchronously set pc_f=RESET_VEC, pend=0, pending target=0, pending class=none.
REQ-033 Reset mid-wait SHALL discard pending redirect; first fetch after release is RESET_VEC.

Structure
REQ-034 brop codes, pending class encoding (none/br/eret/exc) and vector defaults SHALL live in shared package cpu_pkg.
REQ-035 Branch decision and target compute SHALL be sub-module br_resolve (combinational); pc_gen holds registers and priority.

Verification
REQ-036 Reset release -> pc_f=0x3000, pc4_f=0x3004, pend=0, adel_f=0.
REQ-037 pc4_d=0x3008, brop=1, eq=1, idx26[15:0]=0xFFFE -> pc_f=0x3000 next edge; eq=0 -> pc_f=pc_f+4.
REQ-038 fetch_wait=1, is_jr, rs_val=0x3400 -> pend=1, pc_f held; fetch_wait=0 -> pc_f=0x3400, pend=0.
REQ-039 fetch_wait=1, branch latched, then exc_req -> released fetch goes to 0x4180; reversed order also 0x4180.
REQ-040 stall=1, exc_req=1 -> pc_f=0x4180; stall=1, is_j -> pc_f unchanged.
REQ-041 eret_req, epc=0x3002 -> pc_f=0x3002, adel_f=1; epc=0x7000 -> adel_f=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch op codes, pending-redirect classes and fetch vectors
package cpu_pkg;

  typedef enum logic [2:0] {
    BROP_NONE = 3'd0,
    BROP_BEQ  = 3'd1,
    BROP_BNE  = 3'd2,
    BROP_BGTZ = 3'd3,
    BROP_BLEZ = 3'd4,
    BROP_BGEZ = 3'd5,
    BROP_BLTZ = 3'd6,
    BROP_RSVD = 3'd7
  } brop_e;

  // Encoding order is the redirect priority order; merges compare numerically.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_BR   = 2'd1,
    PEND_ERET = 2'd2,
    PEND_EXC  = 2'd3
  } pend_cls_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF     = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF     = 32'h0000_6FFC;

  function automatic logic br_taken(input brop_e op, input logic eq, input logic gt,
                                    input logic lt);
    logic t;
    case (op)
      BROP_BEQ:  t = eq;
      BROP_BNE:  t = ~eq;
      BROP_BGTZ: t = gt;
      BROP_BLEZ: t = ~gt;
      BROP_BGEZ: t = ~lt;
      BROP_BLTZ: t = lt;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic pend_accepts(input pend_cls_e incoming, input pend_cls_e held);
    return (incoming != PEND_NONE) && (incoming >= held);
  endfunction

endpackage

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - D-stage branch/jump decision and redirect target (combinational)
module br_resolve
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc4_d_i,
  input  logic [25:0]       idx26_i,
  input  logic [ADDR_W-1:0] rs_val_i,
  input  logic              eq_i,
  input  logic              gt_i,
  input  logic              lt_i,
  input  logic [2:0]        brop_i,
  input  logic              is_j_i,
  input  logic              is_jr_i,
  output logic              redir_o,
  output logic [ADDR_W-1:0] tgt_o
);

  logic              take_br;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign take_br = br_taken(brop_e'(brop_i), eq_i, gt_i, lt_i);
  assign br_off  = {{(ADDR_W-18){idx26_i[15]}}, idx26_i[15:0], 2'b00};
  assign br_tgt  = pc4_d_i + br_off;
  assign j_tgt   = {pc4_d_i[ADDR_W-1:28], idx26_i, 2'b00};

  assign redir_o = take_br | is_j_i | is_jr_i;

  always_comb begin
    tgt_o = rs_val_i;
    if (take_br) begin
      tgt_o = br_tgt;
    end else if (is_j_i) begin
      tgt_o = j_tgt;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with redirect priority and fetch-wait pending capture
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
  parameter logic [ADDR_W-1:0] IM_LO     = ADDR_W'(IM_LO_DEF),
  parameter logic [ADDR_W-1:0] IM_HI     = ADDR_W'(IM_HI_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_wait,
  input  logic [ADDR_W-1:0] pc4_d,
  input  logic [25:0]       idx26,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              eq,
  input  logic              gt,
  input  logic              lt,
  input  logic [2:0]        brop,
  input  logic              is_j,
  input  logic              is_jr,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_f,
  output logic [ADDR_W-1:0] pc4_f,
  output logic              adel_f,
  output logic              pend
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  pend_cls_e         pend_cls_q, pend_cls_d;

  logic              d_redir_raw;
  logic              d_redir;
  logic [ADDR_W-1:0] d_tgt;
  pend_cls_e         new_cls;
  logic [ADDR_W-1:0] new_tgt;

  br_resolve #(
    .ADDR_W(ADDR_W)
  ) u_br_resolve (
    .pc4_d_i (pc4_d),
    .idx26_i (idx26),
    .rs_val_i(rs_val),
    .eq_i    (eq),
    .gt_i    (gt),
    .lt_i    (lt),
    .brop_i  (brop),
    .is_j_i  (is_j),
    .is_jr_i (is_jr),
    .redir_o (d_redir_raw),
    .tgt_o   (d_tgt)
  );

  // A stalled D stage is not allowed to redirect; exc/eret bypass the stall.
  assign d_redir = d_redir_raw & ~stall;

  always_comb begin
    new_cls = PEND_NONE;
    new_tgt = '0;
    if (exc_req) begin
      new_cls = PEND_EXC;
      new_tgt = EXC_VEC;
    end else if (eret_req) begin
      new_cls = PEND_ERET;
      new_tgt = epc;
    end else if (d_redir) begin
      new_cls = PEND_BR;
      new_tgt = d_tgt;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_cls_d = pend_cls_q;
    pend_tgt_d = pend_tgt_q;
    if (fetch_wait) begin
      if (pend_accepts(new_cls, pend_cls_q)) begin
        pend_cls_d = new_cls;
        pend_tgt_d = new_tgt;
      end
    end else if (exc_req || eret_req) begin
      pc_d       = new_tgt;
      pend_cls_d = PEND_NONE;
      pend_tgt_d = '0;
    end else if (!stall) begin
      if (pend_cls_q != PEND_NONE) begin
        pc_d       = pend_tgt_q;
        pend_cls_d = PEND_NONE;
        pend_tgt_d = '0;
      end else if (d_redir) begin
        pc_d = d_tgt;
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VEC;
      pend_cls_q <= PEND_NONE;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_cls_q <= pend_cls_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_f   = pc_q;
  assign pc4_f  = pc_q + ADDR_W'(4);
  assign pend   = (pend_cls_q != PEND_NONE);
  assign adel_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

endmodule
